// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: Ufop codes, tag constants, entry and dispatch state encodings.
package tomasulo_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam int unsigned TAG_NONE = 0;

  localparam logic [1:0] ST_FREE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_EXEC  = 2'd3;

  localparam logic [1:0] D_IDLE      = 2'd0;
  localparam logic [1:0] D_START     = 2'd1;
  localparam logic [1:0] D_WAIT_DONE = 2'd2;

endpackage

// File: rtl/entrada_estacao_R.sv
// One reservation-station entry: operand storage, CDB snoop, issue-time CDB bypass and state.
module entrada_estacao_R
  import tomasulo_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_issue,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_vj,
  input  logic [DATA_W-1:0] i_vk,
  input  logic [TAG_W-1:0]  i_qj,
  input  logic [TAG_W-1:0]  i_qk,
  input  logic              i_cdb_valid,
  input  logic [TAG_W-1:0]  i_cdb_tag,
  input  logic [DATA_W-1:0] i_cdb_data,
  input  logic              i_dispatch,
  input  logic              i_release,
  output logic [1:0]        o_state,
  output logic [2:0]        o_op,
  output logic [DATA_W-1:0] o_vj,
  output logic [DATA_W-1:0] o_vk
);

  logic [1:0]        r_state;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_vj, r_vk;
  logic [TAG_W-1:0]  r_qj, r_qk;

  logic              w_iss_qj_hit, w_iss_qk_hit, w_snp_qj_hit, w_snp_qk_hit;
  logic [TAG_W-1:0]  w_iss_qj, w_iss_qk, w_qj_next, w_qk_next;

  // A producer broadcasting in the issue cycle would otherwise be missed forever
  assign w_iss_qj_hit = i_cdb_valid && (i_qj != TAG_W'(TAG_NONE)) && (i_qj == i_cdb_tag);
  assign w_iss_qk_hit = i_cdb_valid && (i_qk != TAG_W'(TAG_NONE)) && (i_qk == i_cdb_tag);
  assign w_iss_qj     = w_iss_qj_hit ? '0 : i_qj;
  assign w_iss_qk     = w_iss_qk_hit ? '0 : i_qk;

  assign w_snp_qj_hit = i_cdb_valid && (r_qj != TAG_W'(TAG_NONE)) && (r_qj == i_cdb_tag);
  assign w_snp_qk_hit = i_cdb_valid && (r_qk != TAG_W'(TAG_NONE)) && (r_qk == i_cdb_tag);
  assign w_qj_next    = w_snp_qj_hit ? '0 : r_qj;
  assign w_qk_next    = w_snp_qk_hit ? '0 : r_qk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FREE;
      r_op    <= '0;
      r_vj    <= '0;
      r_vk    <= '0;
      r_qj    <= '0;
      r_qk    <= '0;
    end else begin
      case (r_state)
        ST_FREE: if (i_issue) begin
          r_op    <= i_op;
          r_vj    <= w_iss_qj_hit ? i_cdb_data : i_vj;
          r_vk    <= w_iss_qk_hit ? i_cdb_data : i_vk;
          r_qj    <= w_iss_qj;
          r_qk    <= w_iss_qk;
          r_state <= ((w_iss_qj == '0) && (w_iss_qk == '0)) ? ST_READY : ST_WAIT;
        end
        ST_WAIT: begin
          if (w_snp_qj_hit) r_vj <= i_cdb_data;
          if (w_snp_qk_hit) r_vk <= i_cdb_data;
          r_qj <= w_qj_next;
          r_qk <= w_qk_next;
          if ((w_qj_next == '0) && (w_qk_next == '0)) r_state <= ST_READY;
        end
        ST_READY: if (i_dispatch) r_state <= ST_EXEC;
        ST_EXEC:  if (i_release)  r_state <= ST_FREE;
        default:  r_state <= ST_FREE;
      endcase
    end
  end

  assign o_state = r_state;
  assign o_op    = r_op;
  assign o_vj    = r_vj;
  assign o_vk    = r_vk;

endmodule

// File: rtl/estacao_reserva_r.sv
// R-type reservation station: entry selection for issue and a single-in-flight dispatch FSM.
module estacao_reserva_r
  import tomasulo_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 3,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TAG_W       = 3,
  parameter int unsigned BASE_TAG    = 1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Issue_valid,
  input  logic [2:0]        Issue_op,
  input  logic [DATA_W-1:0] Issue_vj,
  input  logic [DATA_W-1:0] Issue_vk,
  input  logic [TAG_W-1:0]  Issue_qj,
  input  logic [TAG_W-1:0]  Issue_qk,
  output logic [TAG_W-1:0]  Issue_tag,
  output logic              Full,
  input  logic              CDB_valid,
  input  logic [TAG_W-1:0]  CDB_tag,
  input  logic [DATA_W-1:0] CDB_data,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [2:0]        Ufop,
  output logic              Ready_to_uf,
  output logic [TAG_W-1:0]  Uf_tag,
  input  logic              Done
);

  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [1:0]        w_ent_state [NUM_ENTRIES];
  logic [2:0]        w_ent_op    [NUM_ENTRIES];
  logic [DATA_W-1:0] w_ent_vj    [NUM_ENTRIES];
  logic [DATA_W-1:0] w_ent_vk    [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] w_issue_we, w_disp_we, w_rel_we;
  logic                   w_free_found, w_rdy_found, w_complete;
  logic [IDX_W-1:0]       w_free_idx, w_rdy_idx;

  logic [1:0]        r_dstate;
  logic [DATA_W-1:0] r_a, r_b;
  logic [2:0]        r_ufop;
  logic [TAG_W-1:0]  r_uf_tag;
  logic [IDX_W-1:0]  r_exec_idx;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
    entrada_estacao_R #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_ent (
      .clk         (Clock),
      .rst_n       (Resetn),
      .i_issue     (w_issue_we[g]),
      .i_op        (Issue_op),
      .i_vj        (Issue_vj),
      .i_vk        (Issue_vk),
      .i_qj        (Issue_qj),
      .i_qk        (Issue_qk),
      .i_cdb_valid (CDB_valid),
      .i_cdb_tag   (CDB_tag),
      .i_cdb_data  (CDB_data),
      .i_dispatch  (w_disp_we[g]),
      .i_release   (w_rel_we[g]),
      .o_state     (w_ent_state[g]),
      .o_op        (w_ent_op[g]),
      .o_vj        (w_ent_vj[g]),
      .o_vk        (w_ent_vk[g])
    );
  end

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_rdy_found  = 1'b0;
    w_rdy_idx    = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!w_free_found && (w_ent_state[i] == ST_FREE)) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (!w_rdy_found && (w_ent_state[i] == ST_READY)) begin
        w_rdy_found = 1'b1;
        w_rdy_idx   = IDX_W'(i);
      end
    end
  end

  // CMP never raises Done, so its own result broadcast also counts as completion
  assign w_complete = Done || (CDB_valid && (CDB_tag == r_uf_tag));

  always_comb begin
    w_issue_we = '0;
    w_disp_we  = '0;
    w_rel_we   = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      w_issue_we[i] = Issue_valid && w_free_found && (w_free_idx == IDX_W'(i));
      w_disp_we[i]  = (r_dstate == D_IDLE) && w_rdy_found && (w_rdy_idx == IDX_W'(i));
      w_rel_we[i]   = (r_dstate == D_WAIT_DONE) && w_complete && (r_exec_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_dstate   <= D_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_ufop     <= '0;
      r_uf_tag   <= '0;
      r_exec_idx <= '0;
    end else begin
      case (r_dstate)
        D_IDLE: if (w_rdy_found) begin
          r_a        <= w_ent_vj[w_rdy_idx];
          r_b        <= w_ent_vk[w_rdy_idx];
          r_ufop     <= w_ent_op[w_rdy_idx];
          r_uf_tag   <= TAG_W'(BASE_TAG) + TAG_W'(w_rdy_idx);
          r_exec_idx <= w_rdy_idx;
          r_dstate   <= D_START;
        end
        D_START:     r_dstate <= D_WAIT_DONE;
        D_WAIT_DONE: if (w_complete) r_dstate <= D_IDLE;
        default:     r_dstate <= D_IDLE;
      endcase
    end
  end

  assign Full        = !w_free_found;
  assign Issue_tag   = w_free_found ? (TAG_W'(BASE_TAG) + TAG_W'(w_free_idx)) : TAG_W'(TAG_NONE);
  assign A           = r_a;
  assign B           = r_b;
  assign Ufop        = r_ufop;
  assign Uf_tag      = r_uf_tag;
  assign Ready_to_uf = (r_dstate == D_START);

endmodule

// File: tb/tb_estacao_reserva_r.sv
// Scoreboard bench for estacao_reserva_r: expected dispatches queued with stimulus, popped on Ready_to_uf.
module tb_estacao_reserva_r;
  import tomasulo_pkg::*;

  localparam int DW = 16;
  localparam int TW = 3;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          Issue_valid = 1'b0;
  logic [2:0]    Issue_op = '0;
  logic [DW-1:0] Issue_vj = '0, Issue_vk = '0;
  logic [TW-1:0] Issue_qj = '0, Issue_qk = '0;
  logic [TW-1:0] Issue_tag;
  logic          Full;
  logic          CDB_valid = 1'b0;
  logic [TW-1:0] CDB_tag = '0;
  logic [DW-1:0] CDB_data = '0;
  logic [DW-1:0] A, B;
  logic [2:0]    Ufop;
  logic          Ready_to_uf;
  logic [TW-1:0] Uf_tag;
  logic          Done = 1'b0;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    op;
    logic [TW-1:0] tag;
  } disp_t;

  disp_t sb[$];
  int n_pass = 0;
  int n_total = 0;

  estacao_reserva_r #(.NUM_ENTRIES(3), .DATA_W(DW), .TAG_W(TW), .BASE_TAG(1)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .Issue_valid(Issue_valid), .Issue_op(Issue_op),
    .Issue_vj(Issue_vj), .Issue_vk(Issue_vk), .Issue_qj(Issue_qj), .Issue_qk(Issue_qk),
    .Issue_tag(Issue_tag), .Full(Full),
    .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data),
    .A(A), .B(B), .Ufop(Ufop), .Ready_to_uf(Ready_to_uf), .Uf_tag(Uf_tag),
    .Done(Done)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus helpers: all driving happens at negedges, one edge per call.
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] vj, input logic [DW-1:0] vk,
                       input logic [TW-1:0] qj, input logic [TW-1:0] qk, output logic [TW-1:0] tag_seen);
    Issue_valid = 1'b1; Issue_op = op; Issue_vj = vj; Issue_vk = vk; Issue_qj = qj; Issue_qk = qk;
    #1 tag_seen = Issue_tag;
    @(negedge Clock);
    Issue_valid = 1'b0; Issue_qj = '0; Issue_qk = '0;
  endtask

  task automatic cdb(input logic [TW-1:0] tag, input logic [DW-1:0] data);
    CDB_valid = 1'b1; CDB_tag = tag; CDB_data = data;
    @(negedge Clock);
    CDB_valid = 1'b0;
  endtask

  task automatic pulse_done();
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
  endtask

  task automatic quiet(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clock);
      if (Ready_to_uf === 1'b1) pulses++;
    end
  endtask

  // Waits (bounded) for a start pulse, snapshots outputs, pops the expected entry, samples one cycle later.
  task automatic collect(input int max, output bit seen, output int lat,
                         output disp_t obs, output disp_t exp, output logic after);
    lat = 0;
    while (Ready_to_uf !== 1'b1 && lat < max) begin
      @(negedge Clock);
      lat++;
    end
    seen = (Ready_to_uf === 1'b1);
    obs  = {A, B, Ufop, Uf_tag};
    exp  = (sb.size() > 0) ? sb.pop_front() : '0;
    @(negedge Clock);
    after = Ready_to_uf;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clock);
    n_total++;
    if ({A, B, Ufop, Uf_tag, Ready_to_uf, Full} !== '0) $display("FAIL reset_outputs: got %h want 0", {A, B, Ufop, Uf_tag, Ready_to_uf, Full});
    else n_pass++;
    n_total++;
    if (Issue_tag !== 3'd1) $display("FAIL reset_issue_tag: got %0d want 1", Issue_tag);
    else n_pass++;
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_add();
    logic [TW-1:0] t; bit seen; int lat; disp_t obs, exp; logic after;
    sb.push_back({16'd5, 16'd3, OP_ADD, 3'd1});
    issue(OP_ADD, 16'd5, 16'd3, '0, '0, t);
    n_total++;
    if (t !== 3'd1) $display("FAIL add_issue_tag: got %0d want 1", t); else n_pass++;
    collect(20, seen, lat, obs, exp, after);
    n_total++;
    if (!seen) $display("FAIL add_dispatch: no Ready_to_uf within 20 cycles"); else n_pass++;
    n_total++;
    if (lat !== 1) $display("FAIL add_latency: got %0d want 1 cycle after issue edge", lat); else n_pass++;
    n_total++;
    if (obs !== exp) $display("FAIL add_operands: got %h want %h", obs, exp); else n_pass++;
    n_total++;
    if (after !== 1'b0) $display("FAIL add_pulse_width: got %b want 0", after); else n_pass++;
    pulse_done();
    n_total++;
    if (Issue_tag !== 3'd1 || Full !== 1'b0) $display("FAIL add_free: got tag %0d full %b want 1 0", Issue_tag, Full);
    else n_pass++;
  endtask

  task automatic test_cdb_wakeup();
    logic [TW-1:0] t; bit seen; int lat, p; disp_t obs, exp; logic after;
    issue(OP_SUB, 16'd9, 16'd0, '0, 3'd2, t);
    quiet(5, p);
    n_total++;
    if (p !== 0) $display("FAIL sub_pending_hold: got %0d pulses want 0", p); else n_pass++;
    sb.push_back({16'd9, 16'd4, OP_SUB, 3'd1});
    cdb(3'd2, 16'd4);
    collect(20, seen, lat, obs, exp, after);
    n_total++;
    if (!seen || obs !== exp) $display("FAIL sub_wakeup: seen %b got %h want %h", seen, obs, exp); else n_pass++;
    n_total++;
    if (after !== 1'b0) $display("FAIL sub_pulse_width: got %b want 0", after); else n_pass++;
    pulse_done();
    // broadcast lands in the same cycle as the issue
    sb.push_back({16'd7, 16'd6, OP_SUB, 3'd1});
    CDB_valid = 1'b1; CDB_tag = 3'd3; CDB_data = 16'd6;
    issue(OP_SUB, 16'd7, 16'd0, '0, 3'd3, t);
    CDB_valid = 1'b0;
    collect(20, seen, lat, obs, exp, after);
    n_total++;
    if (!seen || obs !== exp) $display("FAIL issue_bypass: seen %b got %h want %h", seen, obs, exp); else n_pass++;
    pulse_done();
  endtask

  task automatic test_full();
    logic [TW-1:0] t1, t2, t3, t4; bit seen; int lat, p; disp_t obs, exp; logic after;
    issue(OP_CMP, 16'd0, 16'd20, 3'd5, '0, t1);
    issue(OP_ADD, 16'd0, 16'd1,  3'd6, '0, t2);
    issue(OP_CMP, 16'd0, 16'd30, 3'd5, '0, t3);
    n_total++;
    if ({t1, t2, t3} !== {3'd1, 3'd2, 3'd3}) $display("FAIL fill_tags: got %0d %0d %0d want 1 2 3", t1, t2, t3);
    else n_pass++;
    n_total++;
    if (Full !== 1'b1) $display("FAIL full_flag: got %b want 1", Full); else n_pass++;
    issue(OP_ADD, 16'd99, 16'd99, '0, '0, t4);
    quiet(5, p);
    n_total++;
    if (p !== 0 || Full !== 1'b1) $display("FAIL full_ignore: got pulses %0d full %b want 0 1", p, Full); else n_pass++;
    sb.push_back({16'd11, 16'd1, OP_ADD, 3'd2});
    cdb(3'd6, 16'd11);
    collect(20, seen, lat, obs, exp, after);
    n_total++;
    if (!seen || obs !== exp) $display("FAIL free_mid_dispatch: seen %b got %h want %h", seen, obs, exp); else n_pass++;
    pulse_done();
    n_total++;
    if (Full !== 1'b0 || Issue_tag !== 3'd2) $display("FAIL free_mid_slot: got full %b tag %0d want 0 2", Full, Issue_tag);
    else n_pass++;
    sb.push_back({16'd50, 16'd8, OP_SUB, 3'd2});
    issue(OP_SUB, 16'd50, 16'd8, '0, '0, t4);
    n_total++;
    if (t4 !== 3'd2) $display("FAIL reuse_tag: got %0d want 2", t4); else n_pass++;
    collect(20, seen, lat, obs, exp, after);
    n_total++;
    if (!seen || obs !== exp) $display("FAIL reuse_dispatch: seen %b got %h want %h", seen, obs, exp); else n_pass++;
    pulse_done();
  endtask

  task automatic test_cmp_order();
    bit seen; int lat; disp_t obs, exp; logic after;
    sb.push_back({16'd40, 16'd20, OP_CMP, 3'd1});
    sb.push_back({16'd40, 16'd30, OP_CMP, 3'd3});
    cdb(3'd5, 16'd40);
    collect(20, seen, lat, obs, exp, after);
    n_total++;
    if (!seen || obs !== exp) $display("FAIL order_first: seen %b got %h want %h", seen, obs, exp); else n_pass++;
    cdb(3'd1, 16'd1);
    collect(20, seen, lat, obs, exp, after);
    n_total++;
    if (!seen || obs !== exp) $display("FAIL cmp_cdb_complete: seen %b got %h want %h", seen, obs, exp); else n_pass++;
    n_total++;
    if (after !== 1'b0) $display("FAIL cmp_pulse_width: got %b want 0", after); else n_pass++;
    cdb(3'd3, 16'd0);
    n_total++;
    if (Full !== 1'b0 || Issue_tag !== 3'd1) $display("FAIL all_free: got full %b tag %0d want 0 1", Full, Issue_tag);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [TW-1:0] t; bit seen; int lat, p; disp_t obs, exp; logic after;
    sb.push_back({16'd13, 16'd17, OP_ADD, 3'd1});
    issue(OP_ADD, 16'd13, 16'd17, '0, '0, t);
    collect(20, seen, lat, obs, exp, after);
    n_total++;
    if (!seen || obs !== exp) $display("FAIL pre_reset_dispatch: seen %b got %h want %h", seen, obs, exp); else n_pass++;
    Resetn = 1'b0;
    #1;
    n_total++;
    if ({A, B, Ufop, Uf_tag, Ready_to_uf, Full} !== '0) $display("FAIL async_reset: got %h want 0", {A, B, Ufop, Uf_tag, Ready_to_uf, Full});
    else n_pass++;
    @(negedge Clock);
    Resetn = 1'b1;
    pulse_done();
    quiet(6, p);
    n_total++;
    if (p !== 0) $display("FAIL post_reset_spurious: got %0d pulses want 0", p); else n_pass++;
    n_total++;
    if (Issue_tag !== 3'd1 || Full !== 1'b0) $display("FAIL post_reset_free: got tag %0d full %b want 1 0", Issue_tag, Full);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_cdb_wakeup();
    test_full();
    test_cmp_order();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
